clk_div_sched: RTL and testbench

- Run/stop and ratio controller for the integer clock-enable divider chain.
- Produces a divided clock-like signal and a one-cycle tick per period.
- Ratio changes arrive over a valid/ready config port. They take effect only at period boundaries, so no runt or stretched periods occur.
- Stop requests drain the current period before the block goes idle.

---
 rtl/clk_div_sched.sv | 191 +++++++++++++++++++
 tb/tb_clk_div_sched.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_sched.sv
// clk_div_sched: run/stop and ratio controller for the integer clock-enable
// divider chain. It generates a registered divided output (q_out) and a
// one-cycle tick at each period start. Ratio updates arrive over a
// valid/ready port and only take effect at period boundaries, so periods are
// never cut short or stretched. A stop request lets the current period finish
// before the block goes idle.
// Optional feature: define CLK_DIV_SCHED_PCNT_EN to add a saturating
// completed-period counter on output pcnt.
module clk_div_sched #(
    parameter int W       = 8,
    parameter int DEF_DIV = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run_i,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         q_out,
    output logic         tick,
    output logic         active,
`ifdef CLK_DIV_SCHED_PCNT_EN
    output logic [W-1:0] div_cur,
    output logic [15:0]  pcnt
`else
    output logic [W-1:0] div_cur
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [W-1:0] DEF_DIV_W = W'(DEF_DIV);

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic           q_out_q, q_out_d;
    logic           tick_q, tick_d;
    logic           cfg_err_q, cfg_err_d;
    logic           cfg_ready_q, cfg_ready_d;
    logic           active_q, active_d;
    logic [W-1:0]   div_cur_q, div_cur_d;
    logic           pend_vld_q, pend_vld_d;
    logic [W-1:0]   pend_div_q, pend_div_d;
    logic [15:0]    pcnt_q, pcnt_d;

    logic           xfer_s;
    logic           bad_div_s;
    logic           boundary_s;
    logic [W:0]     hi_s;
    logic [W:0]     cnt_inc_s;

    // Handshake decode, high-phase length and boundary detection
    always_comb begin
        xfer_s     = cfg_valid && !pend_vld_q;
        bad_div_s  = (cfg_div < W'(2));
        hi_s       = ({1'b0, div_cur_q} + {{W{1'b0}}, 1'b1}) >> 1;
        cnt_inc_s  = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
        boundary_s = (cnt_q == (div_cur_q - W'(1)));
    end

    // Next-state, counter, output and ratio bookkeeping
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        q_out_d    = q_out_q;
        tick_d     = 1'b0;
        cfg_err_d  = xfer_s && bad_div_s;
        div_cur_d  = div_cur_q;
        pend_vld_d = pend_vld_q;
        pend_div_d = pend_div_q;
        pcnt_d     = pcnt_q;

        case (state_q)
            IDLE: begin
                // In IDLE a good ratio lands directly, so a simultaneous
                // start already uses it for the first period.
                if (xfer_s && !bad_div_s) begin
                    div_cur_d = cfg_div;
                end else begin
                    div_cur_d = div_cur_q;
                end
                if (run_i) begin
                    state_d = RUN;
                    cnt_d   = {W{1'b0}};
                    q_out_d = 1'b1;
                    tick_d  = 1'b1;
                    pcnt_d  = 16'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN, DRAIN: begin
                if (boundary_s) begin
                    cnt_d = {W{1'b0}};
                    if (pend_vld_q) begin
                        div_cur_d  = pend_div_q;
                        pend_vld_d = 1'b0;
                    end else begin
                        div_cur_d  = div_cur_q;
                    end
                    if (pcnt_q != 16'hFFFF) begin
                        pcnt_d = pcnt_q + 16'd1;
                    end else begin
                        pcnt_d = pcnt_q;
                    end
                    if ((state_q == DRAIN) && !run_i) begin
                        state_d = IDLE;
                        q_out_d = 1'b0;
                    end else begin
                        state_d = run_i ? RUN : DRAIN;
                        q_out_d = 1'b1;
                        tick_d  = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_inc_s[W-1:0];
                    state_d = run_i ? RUN : DRAIN;
                    if (cnt_inc_s == hi_s) begin
                        q_out_d = 1'b0;
                    end else begin
                        q_out_d = q_out_q;
                    end
                end
                // Stored after the boundary update so a ratio taken on a
                // boundary edge waits for the next boundary.
                if (xfer_s && !bad_div_s) begin
                    pend_vld_d = 1'b1;
                    pend_div_d = cfg_div;
                end else begin
                    pend_div_d = pend_div_q;
                end
            end
            default: begin
                state_d    = IDLE;
                cnt_d      = {W{1'b0}};
                q_out_d    = 1'b0;
                pend_vld_d = 1'b0;
            end
        endcase

        cfg_ready_d = !pend_vld_d;
        active_d    = (state_d != IDLE);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= {W{1'b0}};
            q_out_q     <= 1'b0;
            tick_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
            active_q    <= 1'b0;
            div_cur_q   <= DEF_DIV_W;
            pend_vld_q  <= 1'b0;
            pend_div_q  <= {W{1'b0}};
            pcnt_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            q_out_q     <= q_out_d;
            tick_q      <= tick_d;
            cfg_err_q   <= cfg_err_d;
            cfg_ready_q <= cfg_ready_d;
            active_q    <= active_d;
            div_cur_q   <= div_cur_d;
            pend_vld_q  <= pend_vld_d;
            pend_div_q  <= pend_div_d;
            pcnt_q      <= pcnt_d;
        end
    end

    assign q_out     = q_out_q;
    assign tick      = tick_q;
    assign cfg_err   = cfg_err_q;
    assign cfg_ready = cfg_ready_q;
    assign active    = active_q;
    assign div_cur   = div_cur_q;
`ifdef CLK_DIV_SCHED_PCNT_EN
    assign pcnt      = pcnt_q;
`else
    logic unused_pcnt_s;
    assign unused_pcnt_s = ^pcnt_q;
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: a period-level reference model is
// compared against the DUT every cycle under random run/config stimulus,
// plus a few literal expectations for the startup waveform, error pulse and
// asynchronous reset.
module tb_clk_div_sched;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         run_i = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_div = '0;
    logic         cfg_ready, cfg_err, q_out, tick, active;
    logic [W-1:0] div_cur;
`ifdef CLK_DIV_SCHED_PCNT_EN
    logic [15:0]  pcnt;
`endif

    int total = 0;
    int bad   = 0;

    clk_div_sched #(.W(W), .DEF_DIV(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .run_i     (run_i),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .q_out     (q_out),
        .tick      (tick),
        .active    (active),
`ifdef CLK_DIV_SCHED_PCNT_EN
        .div_cur   (div_cur),
        .pcnt      (pcnt)
`else
        .div_cur   (div_cur)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: position inside the current period plus ratio bookkeeping
    bit m_on   = 1'b0;
    bit m_stop = 1'b0;
    bit m_tick = 1'b0;
    bit m_err  = 1'b0;
    bit m_pv   = 1'b0;
    int m_pos  = 0;
    int m_div  = 5;
    int m_pd   = 0;
    int m_pcnt = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_on = 1'b0; m_stop = 1'b0; m_tick = 1'b0; m_err = 1'b0;
            m_pv = 1'b0; m_pos = 0; m_div = 5; m_pd = 0; m_pcnt = 0;
        end else begin
            bit xfer;
            bit good;
            int d;
            d    = int'(cfg_div);
            xfer = cfg_valid && !m_pv;
            good = xfer && (d >= 2);
            m_err  = xfer && (d < 2);
            m_tick = 1'b0;
            if (!m_on) begin
                if (good) m_div = d;
                if (run_i) begin
                    m_on = 1'b1; m_stop = 1'b0; m_pos = 0; m_tick = 1'b1; m_pcnt = 0;
                end
            end else begin
                if (m_pos == m_div - 1) begin
                    if (m_pv) begin m_div = m_pd; m_pv = 1'b0; end
                    if (m_pcnt < 65535) m_pcnt++;
                    m_pos = 0;
                    if (m_stop && !run_i) m_on = 1'b0;
                    else m_tick = 1'b1;
                end else begin
                    m_pos++;
                end
                m_stop = !run_i;
                if (good) begin m_pv = 1'b1; m_pd = d; end
            end
        end
    end

    // Compare process: every output against the model, away from the active edge
    always @(negedge clk) begin
        bit exp_q;
        exp_q = m_on && (m_pos < (m_div + 1) / 2);
        chk("q_out",     {31'd0, q_out},     {31'd0, exp_q});
        chk("tick",      {31'd0, tick},      {31'd0, m_tick});
        chk("active",    {31'd0, active},    {31'd0, m_on});
        chk("div_cur",   {24'd0, div_cur},   m_div);
        chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, !m_pv});
        chk("cfg_err",   {31'd0, cfg_err},   {31'd0, m_err});
`ifdef CLK_DIV_SCHED_PCNT_EN
        chk("pcnt",      {16'd0, pcnt},      m_pcnt);
`endif
    end

    initial begin
        bit [9:0] qpat;
        bit [9:0] tpat;
        int r;
        qpat = 10'b1110011100;
        tpat = 10'b1000010000;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_q",      {31'd0, q_out},     32'd0);
        chk("rst_div",    {24'd0, div_cur},   32'd5);
        chk("rst_ready",  {31'd0, cfg_ready}, 32'd1);
        chk("rst_active", {31'd0, active},    32'd0);
        rst = 1'b1;

        // Default ratio 5 from the first edge that samples run_i=1
        @(negedge clk);
        run_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("start_q",    {31'd0, q_out}, {31'd0, qpat[9-i]});
            chk("start_tick", {31'd0, tick},  {31'd0, tpat[9-i]});
        end
        chk("start_div",    {24'd0, div_cur}, 32'd5);
        chk("start_active", {31'd0, active},  32'd1);

        // Illegal ratio: single error pulse, ratio untouched
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_div   = 8'd1;
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        chk("err_pulse", {31'd0, cfg_err}, 32'd1);
        chk("err_div",   {24'd0, div_cur}, 32'd5);
        @(negedge clk);
        #1;
        chk("err_clear", {31'd0, cfg_err}, 32'd0);

        // Pending ratio dropped by an asynchronous reset mid-period
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_div   = 8'd9;
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        chk("pend_ready", {31'd0, cfg_ready}, 32'd0);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_q",     {31'd0, q_out},     32'd0);
        chk("arst_div",   {24'd0, div_cur},   32'd5);
        chk("arst_ready", {31'd0, cfg_ready}, 32'd1);
        chk("arst_active",{31'd0, active},    32'd0);
`ifdef CLK_DIV_SCHED_PCNT_EN
        chk("arst_pcnt",  {16'd0, pcnt},      32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // Random run/stop and ratio traffic checked by the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) run_i = ~run_i;
            cfg_valid = ($urandom_range(0, 5) == 0);
            r = int'($urandom_range(0, 24));
            if (r == 0)      cfg_div = 8'd0;
            else if (r == 1) cfg_div = 8'd1;
            else if (r == 2) cfg_div = 8'd255;
            else             cfg_div = 8'($urandom_range(2, 9));
            if (i == 2000) begin
                #2;
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
